// File: rtl/voting.sv
// Four-voter majority block: registers the yes-vote count and a one-hot
// verdict (pass / tie / reject) one cycle after the ballot is sampled.
module voting (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [3:0] In,
  output logic [3:1] Out,
  output logic [2:0] Cnt
);

  localparam logic [3:1] VERDICT_PASS   = 3'b001;
  localparam logic [3:1] VERDICT_TIE    = 3'b010;
  localparam logic [3:1] VERDICT_REJECT = 3'b100;

  logic [3:1] out_d;
  logic [3:1] out_q;
  logic [2:0] cnt_d;
  logic [2:0] cnt_q;

  function automatic logic [2:0] popcount4(input logic [3:0] v);
    logic [2:0] sum;
    sum = 3'd0;
    for (int i = 0; i < 4; i++) begin
      sum = sum + {2'b00, v[i]};
    end
    return sum;
  endfunction

  // Count yes votes and decode the verdict from the count alone.
  always_comb begin
    cnt_d = popcount4(In);
    out_d = VERDICT_REJECT;
    case (cnt_d)
      3'd0, 3'd1: out_d = VERDICT_REJECT;
      3'd2:       out_d = VERDICT_TIE;
      3'd3, 3'd4: out_d = VERDICT_PASS;
      default:    out_d = VERDICT_REJECT;
    endcase
  end

  // Verdict and count share one register stage so they always describe the same sample.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q <= 3'b000;
      cnt_q <= 3'd0;
    end else begin
      out_q <= out_d;
      cnt_q <= cnt_d;
    end
  end

  assign Out = out_q;
  assign Cnt = cnt_q;

endmodule

// File: tb/tb_voting.sv
// Directed bench for voting: expected verdict/count pairs are queued when a
// ballot is driven and compared one edge later.
module tb_voting;

  logic       clk;
  logic       rst_n;
  logic [3:0] In;
  logic [3:1] Out;
  logic [2:0] Cnt;

  logic [5:0] sb[$];
  int n_vec;
  int n_miss;

  voting dut (
    .clk  (clk),
    .rst_n(rst_n),
    .In   (In),
    .Out  (Out),
    .Cnt  (Cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] model(input logic [3:0] v);
    int c;
    logic [2:0] o;
    c = 0;
    for (int i = 0; i < 4; i++) if (v[i] == 1'b1) c++;
    if (c >= 3)      o = 3'b001;
    else if (c == 2) o = 3'b010;
    else             o = 3'b100;
    return {o, 3'(c)};
  endfunction

  task automatic check(input string tag, input logic [5:0] exp);
    n_vec++;
    assert ({Out, Cnt} === exp) else begin
      n_miss++;
      $error("FAIL %s: Out=%b Cnt=%0d expected Out=%b Cnt=%0d", tag, Out, Cnt, exp[5:3], exp[2:0]);
    end
  endtask

  task automatic check_onehot(input string tag);
    n_vec++;
    assert ($onehot(Out)) else begin
      n_miss++;
      $error("FAIL %s onehot: Out=%b expected one-hot", tag, Out);
    end
  endtask

  task automatic drive(input logic [3:0] v);
    In = v;
    sb.push_back(model(v));
  endtask

  // Wait for the edge, then compare the oldest queued expectation.
  task automatic tick_check(input string tag);
    logic [5:0] exp;
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      n_vec++;
      n_miss++;
      $error("FAIL %s: scoreboard empty, Out=%b Cnt=%0d expected a queued entry", tag, Out, Cnt);
    end else begin
      exp = sb.pop_front();
      check(tag, exp);
      check_onehot(tag);
    end
  endtask

  initial begin
    n_vec  = 0;
    n_miss = 0;
    rst_n  = 1'b0;
    In     = 4'b1111;

    // reset holds outputs clear with all-yes ballot and clock running
    #1 check("reset_t1", 6'b000_000);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1 check("reset_edge", 6'b000_000);
    end

    // release between edges; first edge loads the ballot present there
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 16; v++) begin
      drive(4'(v));
      tick_check($sformatf("sweep_%04b", 4'(v)));
    end

    // explicit boundary table
    In = 4'b0000; sb.push_back(6'b100_000); tick_check("tbl_0000");
    In = 4'b0001; sb.push_back(6'b100_001); tick_check("tbl_0001");
    In = 4'b0011; sb.push_back(6'b010_010); tick_check("tbl_0011");
    In = 4'b1100; sb.push_back(6'b010_010); tick_check("tbl_1100");
    In = 4'b1011; sb.push_back(6'b001_011); tick_check("tbl_1011");
    In = 4'b0111; sb.push_back(6'b001_011); tick_check("tbl_0111");
    In = 4'b1111; sb.push_back(6'b001_100); tick_check("tbl_1111");

    // latency: change just after an edge, outputs wait for the next edge
    drive(4'b0000);
    tick_check("lat_pre");
    In = 4'b1110;
    sb.push_back(6'b001_011);
    #3 check("lat_hold", 6'b100_000);
    tick_check("lat_post");

    // mid-cycle glitch has no effect
    drive(4'b0001);
    tick_check("glitch_pre");
    #2 In = 4'b1111;
    #2 In = 4'b0001;
    check("glitch_mid", 6'b100_001);
    sb.push_back(6'b100_001);
    tick_check("glitch_post");

    // asynchronous reset mid-run
    drive(4'b0111);
    tick_check("arst_pre");
    @(negedge clk);
    rst_n = 1'b0;
    #1 check("arst_now", 6'b000_000);
    In = 4'b1010;
    @(posedge clk);
    #1 check("arst_edge", 6'b000_000);
    @(negedge clk);
    rst_n = 1'b1;
    sb.push_back(6'b010_010);
    tick_check("arst_release");

    // short random run
    for (int i = 0; i < 20; i++) begin
      drive(4'($urandom_range(0, 15)));
      tick_check("random");
    end

    if (sb.size() != 0) begin
      n_vec++;
      n_miss++;
      $error("FAIL sb_drain: %0d entries left, expected 0", sb.size());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
